// File: rtl/manchester_pkg.sv
// Shared types and constants for the N-half-bit Manchester decoder.
// Counters are 8 bits wide, so LOCK_PAIRS and MAX_PREAMBLE must stay below 255.
package manchester_pkg;

  typedef enum logic [1:0] {
    ST_HUNT     = 2'd0,
    ST_PREAMBLE = 2'd1,
    ST_DATA     = 2'd2
  } dec_state_t;

  localparam logic [1:0] PAIR_ONE    = 2'b01;
  localparam logic [1:0] PAIR_ZERO   = 2'b10;
  localparam logic [7:0] SFD_DEFAULT = 8'hD5;

  typedef struct packed {
    dec_state_t st;
    logic       pend_v;
    logic       pend_b;
    logic [7:0] lock_cnt;
    logic [7:0] pre_cnt;
    logic [7:0] sreg;
    logic [2:0] bit_cnt;
  } dec_ctx_t;

  localparam dec_ctx_t CTX_RST = '{st: ST_HUNT, default: '0};

  function automatic logic pair_valid(input logic [1:0] p);
    return (p == PAIR_ONE) || (p == PAIR_ZERO);
  endfunction

endpackage

// File: rtl/manchester_pair_step.sv
// One combinational half-bit step of the decoder.
// Chained per half-bit so earlier half-bits affect later ones within the same cycle.
module manchester_pair_step
  import manchester_pkg::*;
#(
  parameter int         LOCK_PAIRS   = 16,
  parameter logic [7:0] SFD          = SFD_DEFAULT,
  parameter int         MAX_PREAMBLE = 64
) (
  input  dec_ctx_t   cur,
  input  logic       en,
  input  logic       hb,
  output dec_ctx_t   nxt,
  output logic       byte_done,
  output logic [7:0] byte_val,
  output logic       sfd_hit,
  output logic       err,
  output logic       fend
);

  localparam logic [7:0] LOCK_LAST = 8'(LOCK_PAIRS - 1);
  localparam logic [7:0] PRE_MAX   = 8'(MAX_PREAMBLE);

  logic [1:0] pair;
  logic [7:0] shifted;
  logic [7:0] pre_nxt;

  assign pair    = {cur.pend_b, hb};
  assign shifted = {cur.sreg[6:0], pair == PAIR_ONE};
  assign pre_nxt = cur.pre_cnt + 8'd1;

  always_comb begin
    nxt       = cur;
    byte_done = 1'b0;
    byte_val  = 8'h00;
    sfd_hit   = 1'b0;
    err       = 1'b0;
    fend      = 1'b0;
    if (en) begin
      if (!cur.pend_v) begin
        nxt.pend_v = 1'b1;
        nxt.pend_b = hb;
      end else begin
        nxt.pend_v = 1'b0;
        case (cur.st)
          ST_HUNT: begin
            if (pair_valid(pair)) begin
              if (cur.lock_cnt == LOCK_LAST) begin
                nxt.st       = ST_PREAMBLE;
                nxt.lock_cnt = '0;
                nxt.pre_cnt  = '0;
                nxt.sreg     = '0;
              end else begin
                nxt.lock_cnt = cur.lock_cnt + 8'd1;
              end
            end else begin
              // slip alignment: the second half-bit starts the next pair
              nxt.pend_v   = 1'b1;
              nxt.pend_b   = hb;
              nxt.lock_cnt = '0;
            end
          end
          ST_PREAMBLE: begin
            if (pair_valid(pair)) begin
              nxt.sreg    = shifted;
              nxt.pre_cnt = pre_nxt;
              if (shifted == SFD) begin
                nxt.st      = ST_DATA;
                nxt.sreg    = '0;
                nxt.bit_cnt = '0;
                sfd_hit     = 1'b1;
              end else if (pre_nxt > PRE_MAX) begin
                nxt.st       = ST_HUNT;
                nxt.lock_cnt = '0;
              end
            end else begin
              err          = 1'b1;
              nxt.st       = ST_HUNT;
              nxt.lock_cnt = '0;
            end
          end
          ST_DATA: begin
            if (pair_valid(pair)) begin
              nxt.sreg    = shifted;
              nxt.bit_cnt = cur.bit_cnt + 3'd1;
              if (cur.bit_cnt == 3'd7) begin
                byte_done = 1'b1;
                byte_val  = shifted;
              end
            end else begin
              err          = 1'b1;
              fend         = 1'b1;
              nxt.st       = ST_HUNT;
              nxt.lock_cnt = '0;
              nxt.bit_cnt  = '0;
            end
          end
          default: nxt.st = ST_HUNT;
        endcase
      end
    end
  end

endmodule

// File: rtl/manchester_decoder_n.sv
// Manchester decoder consuming 0..MAX_BITS recovered half-bits per cycle.
// Handles pair alignment, lock, SFD detection and MSB-first byte assembly.
module manchester_decoder_n
  import manchester_pkg::*;
#(
  parameter int         MAX_BITS     = 3,
  parameter int         NB_W         = $clog2(MAX_BITS + 1),
  parameter int         LOCK_PAIRS   = 16,
  parameter logic [7:0] SFD          = SFD_DEFAULT,
  parameter int         MAX_PREAMBLE = 64
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic [MAX_BITS-1:0] bits,
  input  logic [NB_W-1:0]     num_bits,
  output logic [7:0]          out_data,
  output logic                out_valid,
  output logic                frame_start,
  output logic                frame_end,
  output logic                code_err,
  output logic                locked
);

  dec_ctx_t ctx;
  dec_ctx_t chain [MAX_BITS+1];

  logic [MAX_BITS-1:0]       en, bd, sh, er, fe;
  logic [MAX_BITS-1:0][7:0]  bv;
  logic [MAX_BITS-1:0]       aligned;
  logic [NB_W-1:0]           sh_amt;
  logic                      legal;
  logic [7:0]                byte_sel;

  assign legal   = (num_bits <= NB_W'(MAX_BITS));
  assign sh_amt  = NB_W'(MAX_BITS) - num_bits;
  // oldest half-bit lands on the MSB so step i reads aligned[MAX_BITS-1-i]
  assign aligned = bits << sh_amt;
  assign chain[0] = ctx;

  for (genvar i = 0; i < MAX_BITS; i++) begin : g_step
    assign en[i] = legal && (NB_W'(i) < num_bits);
    manchester_pair_step #(
      .LOCK_PAIRS  (LOCK_PAIRS),
      .SFD         (SFD),
      .MAX_PREAMBLE(MAX_PREAMBLE)
    ) u_step (
      .cur      (chain[i]),
      .en       (en[i]),
      .hb       (aligned[MAX_BITS-1-i]),
      .nxt      (chain[i+1]),
      .byte_done(bd[i]),
      .byte_val (bv[i]),
      .sfd_hit  (sh[i]),
      .err      (er[i]),
      .fend     (fe[i])
    );
  end

  always_comb begin
    byte_sel = 8'h00;
    for (int i = 0; i < MAX_BITS; i++)
      byte_sel = byte_sel | (bv[i] & {8{bd[i]}});
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ctx         <= CTX_RST;
      out_data    <= 8'h00;
      out_valid   <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      code_err    <= 1'b0;
      locked      <= 1'b0;
    end else if (!legal) begin
      out_valid   <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      code_err    <= 1'b1;
    end else begin
      ctx         <= chain[MAX_BITS];
      out_valid   <= |bd;
      if (|bd) out_data <= byte_sel;
      frame_start <= |sh;
      frame_end   <= |fe;
      code_err    <= |er;
      locked      <= (chain[MAX_BITS].st != ST_HUNT);
    end
  end

endmodule

// File: tb/tb_manchester_decoder_n.sv
// Directed bench for manchester_decoder_n with MAX_BITS=3 and a widened num_bits port.
module tb_manchester_decoder_n;

  logic       aclk = 1'b0;
  logic       aresetn;
  logic [2:0] bits;
  logic [2:0] num_bits;
  logic [7:0] out_data;
  logic       out_valid, frame_start, frame_end, code_err, locked;

  int tests = 0;
  int fails = 0;
  int fs_cnt = 0, fe_cnt = 0, err_cnt = 0, both_cnt = 0;
  logic [7:0] got[$];
  logic       hq[$];
  int base, fs0, fe0, err0, both0;

  always #5 aclk = ~aclk;

  manchester_decoder_n #(.MAX_BITS(3), .NB_W(3)) dut (
    .aclk(aclk), .aresetn(aresetn), .bits(bits), .num_bits(num_bits),
    .out_data(out_data), .out_valid(out_valid), .frame_start(frame_start),
    .frame_end(frame_end), .code_err(code_err), .locked(locked)
  );

  always @(negedge aclk) begin
    if (aresetn) begin
      if (out_valid) got.push_back(out_data);
      if (frame_start) fs_cnt++;
      if (frame_end) fe_cnt++;
      if (code_err) err_cnt++;
      if (code_err && frame_end) both_cnt++;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // bit 1 -> pair 01, bit 0 -> pair 10, sent in time order
  task automatic push_byte(input logic [7:0] b);
    for (int k = 7; k >= 0; k--) begin
      hq.push_back(~b[k]);
      hq.push_back(b[k]);
    end
  endtask

  task automatic push_frame();
    push_byte(8'hAA); push_byte(8'hAA); push_byte(8'hD5);
    push_byte(8'hAA); push_byte(8'hBB); push_byte(8'hCC); push_byte(8'hDD);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge aclk);
      num_bits = 3'd0;
      bits     = 3'd0;
    end
  endtask

  // per==0 draws a random chunk size 0..3 each cycle; cnt<0 sends the whole queue
  task automatic send(input int per, input int cnt);
    int left, n;
    logic [2:0] vec;
    left = (cnt < 0) ? hq.size() : cnt;
    while (left > 0) begin
      n = (per == 0) ? int'($urandom_range(0, 3)) : per;
      if (n > left) n = left;
      vec = 3'd0;
      for (int k = 0; k < n; k++) vec[n-1-k] = hq.pop_front();
      @(negedge aclk);
      bits     = vec;
      num_bits = 3'(n);
      left     = left - n;
    end
    idle(3);
  endtask

  task automatic do_reset();
    @(negedge aclk);
    aresetn  = 1'b0;
    bits     = 3'd0;
    num_bits = 3'd0;
    hq.delete();
    idle(2);
    aresetn = 1'b1;
    idle(1);
  endtask

  task automatic snap();
    base = got.size(); fs0 = fs_cnt; fe0 = fe_cnt; err0 = err_cnt; both0 = both_cnt;
  endtask

  function automatic logic [31:0] bytes4();
    logic [31:0] r = 32'h0;
    for (int i = 0; i < 4; i++)
      r = {r[23:0], (base + i < got.size()) ? got[base+i] : 8'h00};
    return r;
  endfunction

  task automatic check_frame(input string tag);
    check({tag, "_nbytes"}, got.size() - base, 4);
    check({tag, "_bytes"}, bytes4(), 32'hAABBCCDD);
    check({tag, "_fs"}, fs_cnt - fs0, 1);
    check({tag, "_err"}, err_cnt - err0, 0);
    check({tag, "_fe"}, fe_cnt - fe0, 0);
  endtask

  initial begin
    aresetn = 1'b0; bits = 3'd0; num_bits = 3'd0;
    idle(2);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_frame_start", frame_start, 0);
    check("rst_frame_end", frame_end, 0);
    check("rst_code_err", code_err, 0);
    check("rst_locked", locked, 0);
    aresetn = 1'b1;
    idle(1);

    // 2 half-bits/cycle, lock boundary at exactly 16 pairs
    snap(); push_frame();
    send(2, 30);
    check("lock_15_pairs", locked, 0);
    send(2, 2);
    check("lock_16_pairs", locked, 1);
    send(2, -1);
    check_frame("p2");
    check("p2_locked", locked, 1);

    do_reset(); snap(); push_frame(); send(3, -1);
    check_frame("p3");

    do_reset(); snap(); push_frame(); send(0, -1);
    check_frame("rnd");

    // stray leading half-bit forces a slip; extra preamble byte keeps SFD reachable
    do_reset(); snap();
    hq.push_back(1'b1); push_byte(8'hAA); push_frame();
    send(2, -1);
    check_frame("slip");

    // pair 00 after byte BB
    do_reset(); snap();
    push_byte(8'hAA); push_byte(8'hAA); push_byte(8'hD5); push_byte(8'hAA); push_byte(8'hBB);
    hq.push_back(1'b0); hq.push_back(1'b0);
    push_byte(8'hCC);
    send(2, -1);
    check("viol_nbytes", got.size() - base, 2);
    check("viol_bytes", bytes4(), 32'hAABB0000);
    check("viol_err", err_cnt - err0, 1);
    check("viol_fe", fe_cnt - fe0, 1);
    check("viol_together", both_cnt - both0, 1);
    check("viol_locked", locked, 0);
    snap(); push_frame(); send(2, -1);
    check_frame("resend");

    // preamble overrun: 16 lock pairs + 72 preamble bits without SFD
    do_reset(); snap();
    for (int i = 0; i < 11; i++) push_byte(8'hAA);
    send(2, -1);
    check("ovr_locked", locked, 0);
    check("ovr_fs", fs_cnt - fs0, 0);
    check("ovr_err", err_cnt - err0, 0);

    // illegal num_bits while locked leaves state untouched
    do_reset(); snap();
    push_byte(8'hAA); push_byte(8'hAA);
    send(2, -1);
    check("ill_pre_locked", locked, 1);
    @(negedge aclk);
    bits = 3'b111; num_bits = 3'd5;
    idle(3);
    check("ill_err", err_cnt - err0, 1);
    check("ill_locked", locked, 1);
    snap();
    push_byte(8'hD5); push_byte(8'hAA); push_byte(8'hBB); push_byte(8'hCC); push_byte(8'hDD);
    send(2, -1);
    check_frame("ill_after");

    // reset mid-DATA after byte AA
    do_reset(); snap();
    push_byte(8'hAA); push_byte(8'hAA); push_byte(8'hD5); push_byte(8'hAA); push_byte(8'hBB);
    send(2, 64);
    check("mid_byte_aa", (got.size() - base == 1) ? got[base] : 8'hFF, 8'hAA);
    check("mid_locked_before", locked, 1);
    fe0 = fe_cnt;
    @(negedge aclk);
    aresetn = 1'b0; num_bits = 3'd2; bits = 3'b011;
    @(negedge aclk);
    check("mid_outputs", {out_valid, out_data, frame_start, frame_end, code_err, locked}, 0);
    check("mid_fe", fe_cnt - fe0, 0);
    do_reset(); snap(); push_frame(); send(2, -1);
    check_frame("post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
